// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer with a small word register file.
//   IDX 0..NUM_REG-3 : read/write scratch (register 0 is driven out on CTRL)
//   IDX NUM_REG-2    : read-only identification word ID_VALUE
//   IDX NUM_REG-1    : read-only count of completed transfers (XCNT)
// Each transfer inserts WAIT_CYCLES wait states. Request fields are captured
// in the setup phase, so changes during ACCESS are ignored.
// Optional build macro APB_SLV_PSTRB_EN adds the PSTRB port and byte-lane
// write enables. Without it, every write updates all four bytes.
module apb_reg_slave #(
  parameter int          WIDTH_PAD   = 32,
  parameter int          WIDTH_PDA   = 32,
  parameter int          NUM_REG     = 8,
  parameter int          ADDR_LENGTH = 12,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [WIDTH_PAD-1:0]   PADDR,
  input  logic [WIDTH_PDA-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [WIDTH_PDA/8-1:0] PSTRB,
`endif
  output logic [WIDTH_PDA-1:0]   PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [31:0]            CTRL
);

  localparam int NB = WIDTH_PDA / 8;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                         state, state_nxt;
  logic [3:0]                     wcnt, wcnt_nxt;
  logic [ADDR_LENGTH-1:0]         addr_q;
  logic                           wr_q;
  logic [WIDTH_PDA-1:0]           wdata_q;
  logic [NB-1:0]                  strb_q;
  logic [WIDTH_PDA-1:0]           wmask;
  logic [NUM_REG-3:0][WIDTH_PDA-1:0] scratch;
  logic [31:0]                    xcnt;
  logic [31:0]                    idx;
  logic [WIDTH_PDA-1:0]           rdata;
  logic                           setup, done, err, we;

  // Upper address bits are qualified by the interconnect through PSEL.
  logic unused_addr;
  assign unused_addr = ^PADDR;

  assign setup = (state == IDLE) && PSEL && !PENABLE;
  assign done  = (state == ACCESS) && PSEL && (wcnt == 4'd0);
  assign idx   = 32'(addr_q[ADDR_LENGTH-1:2]);
  assign err   = (idx >= 32'(NUM_REG)) || (addr_q[1:0] != 2'b00) ||
                 (wr_q && (idx >= 32'(NUM_REG - 2)));
  assign we    = done && wr_q && !err;

  // State and wait-counter register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next state: dropping PSEL in ACCESS abandons the transfer.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = ACCESS;
          wcnt_nxt  = 4'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_nxt = IDLE;
          wcnt_nxt  = 4'd0;
        end else if (wcnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = 4'd0;
      end
    endcase
  end

  // Capture the request in the setup phase.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (setup) begin
      addr_q  <= PADDR[ADDR_LENGTH-1:0];
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
    end
  end

`ifdef APB_SLV_PSTRB_EN
  // Byte strobes travel with the rest of the request.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)     strb_q <= '0;
    else if (setup) strb_q <= PSTRB;
  end
`else
  assign strb_q = '1;
`endif

  // Expand byte strobes into a bit mask.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) wmask[8*b +: 8] = {8{strb_q[b]}};
  end

  // Scratch registers update on the edge that ends the completion cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      scratch <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REG - 2; i++)
        if (idx == 32'(i)) scratch[i] <= (scratch[i] & ~wmask) | (wdata_q & wmask);
    end
  end

  // Transfer counter: every completed transfer, errored or not; wraps.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)    xcnt <= 32'd0;
    else if (done) xcnt <= xcnt + 32'd1;
  end

  // Read mux; errored accesses read as zero.
  always_comb begin
    rdata = '0;
    if (!err) begin
      if (idx == 32'(NUM_REG - 2))      rdata = ID_VALUE;
      else if (idx == 32'(NUM_REG - 1)) rdata = xcnt;
      else begin
        for (int i = 0; i < NUM_REG - 2; i++)
          if (idx == 32'(i)) rdata = scratch[i];
      end
    end
  end

  // Responses are only non-zero in the completion cycle.
  assign PREADY  = done;
  assign PSLVERR = done && err;
  assign PRDATA  = (done && !wr_q) ? rdata : '0;
  assign CTRL    = scratch[0];

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter WIDTH_PAD, default 32, meaning APB address width.
REQ-002 SHALL have parameter WIDTH_PDA, default 32, meaning APB data width; only 32 is supported.
REQ-003 SHALL have parameter NUM_REG, default 8, meaning number of 32-bit word registers (minimum 3).
REQ-004 SHALL have parameter ADDR_LENGTH, default 12, meaning the address bits decoded inside the slave window.
REQ-005 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning wait states inserted per transfer.
REQ-006 SHALL have parameter ID_VALUE, default 32'hA5B0_0001, meaning the read-only identification word.
REQ-007 Ports: PCLK  in  1  clock; all logic on rising edge.
REQ-008 PRESET  in  1  asynchronous, active-high reset.
REQ-009 PSEL in 1, PENABLE in 1, PWRITE in 1, PADDR in WIDTH_PAD, PWDATA in WIDTH_PDA: APB requester signals.
REQ-010 PRDATA out WIDTH_PDA, PREADY out 1, PSLVERR out 1: APB completer responses.
REQ-011 PSTRB in WIDTH_PDA/8: write byte strobes; present only under APB_SLV_PSTRB_EN.
REQ-012 CTRL out 32: current content of register 0.

Function
REQ-013 SHALL decode word index IDX = PADDR[ADDR_LENGTH-1:2]; higher address bits are ignored, because the interconnect qualifies PSEL.
REQ-014 Register map: IDX 0..NUM_REG-3 are read/write scratch; IDX NUM_REG-2 is read-only ID_VALUE; IDX NUM_REG-1 is the read-only 32-bit transfer counter XCNT.
REQ-015 SHALL implement FSM IDLE -> ACCESS -> IDLE:
- IDLE: on PSEL=1 and PENABLE=0, load the wait counter with WAIT_CYCLES and go to ACCESS.
- ACCESS: the counter decrements each cycle while above 0.
- ACCESS with counter 0: the transfer completes; return to IDLE.
REQ-016 PREADY SHALL be 1 only in ACCESS with counter 0; a setup phase at cycle T completes at cycle T+1+WAIT_CYCLES.
REQ-017 PRDATA and PSLVERR SHALL be 0 except in the completion cycle.
REQ-018 A read SHALL return the addressed register in the completion cycle; an errored read returns 0.
REQ-019 A write SHALL update the register at the clock edge that ends the completion cycle, and never earlier.
REQ-020 PSLVERR=1 SHALL be signalled for: IDX >= NUM_REG, PADDR[1:0] != 0, or a write to the ID or XCNT register. An errored write SHALL change no register.
REQ-021 XCNT SHALL increment by 1 on every completed transfer, errored or not, and wrap from FFFF_FFFF to 0. A read of XCNT returns the value before the current transfer's increment.
REQ-022 If PSEL drops while in ACCESS before completion, the FSM SHALL return to IDLE with no write and no XCNT increment.
REQ-023 PADDR, PWRITE, PWDATA and PSTRB SHALL be captured at the setup phase, so that changes during ACCESS are ignored.
REQ-024 PSEL=1 with PENABLE=1 while in IDLE SHALL be ignored; the slave stays in IDLE with PREADY=0.
REQ-025 Back-to-back transfers SHALL be supported: a new setup phase in the cycle after completion is accepted.

Reset
REQ-026 While PRESET=1: FSM in IDLE, wait counter 0, all registers 0, XCNT 0, PREADY=0, PSLVERR=0, PRDATA=0, CTRL=0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer immediately, with no register update.

Configuration
REQ-028 Macro APB_SLV_PSTRB_EN defined: the PSTRB port exists, and byte lane i is written only when PSTRB[i]=1. A write with PSTRB=0 changes no byte and is not an error.
REQ-029 Macro APB_SLV_PSTRB_EN undefined: the PSTRB port is absent, and every write updates all 4 bytes.

Verification
REQ-030 WAIT_CYCLES=1, write 0x1234_5678 to PADDR 0x000, then read 0x000 -> PREADY at T+2 both times, read data 0x1234_5678, CTRL=0x1234_5678, PSLVERR=0.
REQ-031 Read PADDR 0x018 (NUM_REG=8) -> 0xA5B0_0001. Write 0x018 -> PSLVERR=1 and ID unchanged. Read 0x020 -> PSLVERR=1, PRDATA=0.
REQ-032 After 3 completed transfers, read 0x01C -> 3. Preload XCNT=FFFF_FFFF by force, complete one transfer -> XCNT=0.
REQ-033 APB_SLV_PSTRB_EN, reg1=0xFFFF_FFFF, write 0x0 with PSTRB=4'b0101 -> reg1=0xFF00_FF00.
REQ-034 WAIT_CYCLES=3, drop PSEL at T+2 during a write -> no PREADY, register unchanged, XCNT unchanged; assert PRESET mid-transfer -> all outputs 0 immediately.
